// File: rtl/line_buff_ctrl.sv
// Ping-pong line buffer controller: primes both buffers, aligns to frame start,
// then swaps display/refill roles every tile row and flags late fills.
module line_buff_ctrl #(
  parameter int unsigned WIDTH_PX       = 640,
  parameter int unsigned HEIGHT_PX      = 480,
  parameter int unsigned TILE_WIDTH     = 4,
  parameter int unsigned CTR_WIDTH      = 10,
  parameter int unsigned TILE_PER_LINE  = WIDTH_PX / TILE_WIDTH,
  parameter int unsigned TILE_CTR_WIDTH = $clog2(TILE_PER_LINE)
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      pxl_en_i,
  input  logic [CTR_WIDTH-1:0]      pxl_ctr_i,
  input  logic [CTR_WIDTH-1:0]      line_ctr_i,
  input  logic [1:0]                buff_fill_done_i,
  output logic [1:0]                buff_fill_req_o,
  output logic [1:0]                buff_sel_o,
  output logic [TILE_CTR_WIDTH-1:0] disp_pxl_id_o,
  output logic                      ready_o,
  output logic                      underrun_o
);

  localparam int unsigned TILE_SHIFT = $clog2(TILE_WIDTH);

  // Tile rows must pair up so the frame wraps onto buffer 0; tile edge is a power of 2.
  if (((HEIGHT_PX / TILE_WIDTH) % 2) != 0) begin : g_bad_height
    $error("HEIGHT_PX/TILE_WIDTH must be even");
  end
  if ((TILE_WIDTH < 2) || ((TILE_WIDTH & (TILE_WIDTH - 1)) != 0)) begin : g_bad_tile
    $error("TILE_WIDTH must be a power of 2");
  end

  typedef enum logic [1:0] {PRIME_A, PRIME_B, SYNC, RUN} state_e;

  state_e                    state_q, state_d;
  logic [1:0]                req_q, req_d;
  logic [1:0]                sel_q, sel_d;
  logic [TILE_CTR_WIDTH-1:0] id_q, id_d;
  logic                      ready_q, ready_d;
  logic                      underrun_q, underrun_d;

  logic sync_c;
  logic swap_c;
  logic pxl_active_c;

  assign sync_c = pxl_en_i && (pxl_ctr_i == '0) && (line_ctr_i == '0);
  assign swap_c = pxl_en_i
               && (pxl_ctr_i == CTR_WIDTH'(WIDTH_PX - 1))
               && (line_ctr_i < CTR_WIDTH'(HEIGHT_PX))
               && ((line_ctr_i & CTR_WIDTH'(TILE_WIDTH - 1)) == CTR_WIDTH'(TILE_WIDTH - 1));
  assign pxl_active_c = pxl_ctr_i < CTR_WIDTH'(WIDTH_PX);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= PRIME_A;
      req_q      <= '0;
      sel_q      <= '0;
      id_q       <= '0;
      ready_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      sel_q      <= sel_d;
      id_q       <= id_d;
      ready_q    <= ready_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    sel_d      = sel_q;
    id_d       = '0;
    underrun_d = underrun_q;
    unique case (state_q)
      PRIME_A: begin
        if (req_q[0] && buff_fill_done_i[0]) begin
          state_d = PRIME_B;
          req_d   = 2'b10;
        end else begin
          req_d   = 2'b01;
        end
      end
      PRIME_B: begin
        if (req_q[1] && buff_fill_done_i[1]) begin
          state_d = SYNC;
          req_d   = 2'b00;
        end else begin
          req_d   = 2'b10;
        end
      end
      SYNC: begin
        req_d = 2'b00;
        sel_d = 2'b00;
        if (sync_c) begin
          state_d = RUN;
          sel_d   = 2'b01;
        end
      end
      RUN: begin
        req_d = req_q & ~buff_fill_done_i;
        id_d  = pxl_active_c ? TILE_CTR_WIDTH'(pxl_ctr_i >> TILE_SHIFT)
                             : TILE_CTR_WIDTH'(TILE_PER_LINE - 1);
        // Buffer being released gets refilled; the incoming one must already be full.
        if (swap_c) begin
          sel_d = ~sel_q;
          if ((req_d & ~sel_q) != 2'b00) underrun_d = 1'b1;
          req_d = req_d | sel_q;
        end
      end
      default: state_d = PRIME_A;
    endcase
    ready_d = (state_d == RUN);
  end

  assign buff_fill_req_o = req_q;
  assign buff_sel_o      = sel_q;
  assign disp_pxl_id_o   = id_q;
  assign ready_o         = ready_q;
  assign underrun_o      = underrun_q;

endmodule

// File: tb/tb_line_buff_ctrl.sv
// Scoreboard bench for line_buff_ctrl: directed steps push expected outputs,
// a monitor pops and compares after each clock edge or async reset.
module tb_line_buff_ctrl;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b0;
  logic       pxl_en_i = 1'b0;
  logic [9:0] pxl_ctr_i = '0;
  logic [9:0] line_ctr_i = '0;
  logic [1:0] buff_fill_done_i = '0;
  logic [1:0] buff_fill_req_o;
  logic [1:0] buff_sel_o;
  logic [7:0] disp_pxl_id_o;
  logic       ready_o;
  logic       underrun_o;

  line_buff_ctrl dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .pxl_en_i         (pxl_en_i),
    .pxl_ctr_i        (pxl_ctr_i),
    .line_ctr_i       (line_ctr_i),
    .buff_fill_done_i (buff_fill_done_i),
    .buff_fill_req_o  (buff_fill_req_o),
    .buff_sel_o       (buff_sel_o),
    .disp_pxl_id_o    (disp_pxl_id_o),
    .ready_o          (ready_o),
    .underrun_o       (underrun_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string      name;
    logic [1:0] req;
    logic [1:0] sel;
    logic [7:0] id;
    logic       rdy;
    logic       unr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic drive(input logic en, input int pxl, input int line, input logic [1:0] done);
    pxl_en_i         = en;
    pxl_ctr_i        = 10'(pxl);
    line_ctr_i       = 10'(line);
    buff_fill_done_i = done;
  endtask

  task automatic expect_out(input string name, input logic [1:0] req, input logic [1:0] sel,
                            input int id, input logic rdy, input logic unr);
    exp_t e;
    e.name = name; e.req = req; e.sel = sel; e.id = 8'(id); e.rdy = rdy; e.unr = unr;
    exp_q.push_back(e);
  endtask

  task automatic step(input string name, input logic en, input int pxl, input int line,
                      input logic [1:0] done, input logic [1:0] req, input logic [1:0] sel,
                      input int id, input logic rdy, input logic unr);
    @(negedge clk_i);
    drive(en, pxl, line, done);
    expect_out(name, req, sel, id, rdy, unr);
  endtask

  // Monitor: one popped expectation per clock edge or reset assertion.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i or negedge rstn_i);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (buff_fill_req_o !== e.req || buff_sel_o !== e.sel || disp_pxl_id_o !== e.id ||
            ready_o !== e.rdy || underrun_o !== e.unr) begin
          n_bad++;
          $display("FAIL %s: got req=%b sel=%b id=%0d rdy=%b unr=%b, want req=%b sel=%b id=%0d rdy=%b unr=%b",
                   e.name, buff_fill_req_o, buff_sel_o, disp_pxl_id_o, ready_o, underrun_o,
                   e.req, e.sel, e.id, e.rdy, e.unr);
        end
      end
    end
  end

  initial begin
    // Reset state
    step("reset_state", 1'b0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk_i);

    // Priming
    @(negedge clk_i);
    rstn_i = 1'b1;
    drive(1'b0, 0, 0, 2'b00);
    expect_out("prime_a_first_edge", 2'b01, 2'b00, 0, 1'b0, 1'b0);
    step("prime_a_hold",  1'b0, 0, 0, 2'b00, 2'b01, 2'b00, 0, 1'b0, 1'b0);
    step("prime_b",       1'b0, 0, 0, 2'b01, 2'b10, 2'b00, 0, 1'b0, 1'b0);
    step("stray_done0",   1'b0, 0, 0, 2'b01, 2'b10, 2'b00, 0, 1'b0, 1'b0);
    step("sync_wait",     1'b0, 0, 0, 2'b10, 2'b00, 2'b00, 0, 1'b0, 1'b0);

    // Sync to frame start
    step("sync_hold_pxl5",   1'b1, 5, 0, 2'b00, 2'b00, 2'b00, 0, 1'b0, 1'b0);
    step("sync_hold_en_low", 1'b0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1'b0, 1'b0);
    step("sync_go",          1'b1, 0, 0, 2'b00, 2'b00, 2'b01, 0, 1'b1, 1'b0);
    step("pxl_id_8",         1'b1, 8, 0, 2'b00, 2'b00, 2'b01, 2, 1'b1, 1'b0);
    step("no_swap_line0",    1'b1, 639, 0, 2'b00, 2'b00, 2'b01, 159, 1'b1, 1'b0);
    step("no_swap_en_low",   1'b0, 639, 3, 2'b00, 2'b00, 2'b01, 159, 1'b1, 1'b0);

    // Swaps with on-time fills
    step("swap_row0",   1'b1, 639, 3, 2'b00, 2'b01, 2'b10, 159, 1'b1, 1'b0);
    step("fill0_done",  1'b1, 0,   4, 2'b01, 2'b00, 2'b10, 0,   1'b1, 1'b0);
    step("swap_row1",   1'b1, 639, 7, 2'b00, 2'b10, 2'b01, 159, 1'b1, 1'b0);
    step("fill1_done",  1'b1, 100, 8, 2'b10, 2'b00, 2'b01, 25,  1'b1, 1'b0);
    step("swap_row2",   1'b1, 639, 11, 2'b00, 2'b01, 2'b10, 159, 1'b1, 1'b0);

    // Underrun: done[0] withheld across the swap
    step("underrun",        1'b1, 639, 15, 2'b00, 2'b11, 2'b01, 159, 1'b1, 1'b1);
    step("underrun_sticky", 1'b1, 637, 16, 2'b00, 2'b11, 2'b01, 159, 1'b1, 1'b1);
    step("pxl_700",         1'b1, 700, 16, 2'b11, 2'b00, 2'b01, 159, 1'b1, 1'b1);

    // Frame wrap
    step("swap_row118",     1'b1, 639, 475, 2'b00, 2'b01, 2'b10, 159, 1'b1, 1'b1);
    step("fill_next_row0",  1'b1, 0,   476, 2'b01, 2'b00, 2'b10, 0,   1'b1, 1'b1);
    step("wrap_line479",    1'b1, 639, 479, 2'b00, 2'b10, 2'b01, 159, 1'b1, 1'b1);
    step("vblank_no_swap",  1'b1, 639, 483, 2'b10, 2'b00, 2'b01, 159, 1'b1, 1'b1);
    step("f2_swap_row0",    1'b1, 639, 3,   2'b00, 2'b01, 2'b10, 159, 1'b1, 1'b1);
    step("swap_done_same_edge", 1'b1, 639, 7, 2'b01, 2'b10, 2'b01, 159, 1'b1, 1'b1);

    // Asynchronous reset while req=10
    @(negedge clk_i);
    drive(1'b0, 0, 0, 2'b00);
    expect_out("async_reset", 2'b00, 2'b00, 0, 1'b0, 1'b0);
    #2 rstn_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    expect_out("restart_prime_a", 2'b01, 2'b00, 0, 1'b0, 1'b0);
    step("restart_prime_b", 1'b0, 0, 0, 2'b01, 2'b10, 2'b00, 0, 1'b0, 1'b0);

    repeat (4) @(posedge clk_i);
    #2;
    if (exp_q.size() != 0) begin
      $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
      n_bad += exp_q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
